// File: rtl/keccak_padder_multi_if.sv
// Message-side and permutation-side handshake bundle for the Keccak padder.
// The master drives words and acks. The slave (padder) returns assembled blocks.
interface keccak_padder_multi_if #(
    parameter int IN_W = 32
);
    localparam int BN_W = $clog2(IN_W / 8);

    logic [1:0]      mode;
    logic [IN_W-1:0] in;
    logic            in_ready;
    logic            is_last;
    logic [BN_W-1:0] byte_num;
    logic            buffer_full;
    logic [1151:0]   out;
    logic            out_ready;
    logic            out_last;
    logic            f_ack;

    modport master (
        output mode, in, in_ready, is_last, byte_num, f_ack,
        input  buffer_full, out, out_ready, out_last
    );

    modport slave (
        input  mode, in, in_ready, is_last, byte_num, f_ack,
        output buffer_full, out, out_ready, out_last
    );
endinterface

// File: rtl/keccak_padder_multi.sv
// Keccak multi-rate padder: packs IN_W-bit message words into rate-sized blocks
// and applies pad10*1 with a selectable domain byte on the final word.
module keccak_padder_multi #(
    parameter int IN_W     = 32,
    parameter bit SHA3_PAD = 1'b0
) (
    input logic                  clk,
    input logic                  reset,
    keccak_padder_multi_if.slave bus
);
    localparam int BPW     = IN_W / 8;
    localparam int MAX_WPB = 1152 / IN_W;
    localparam int CNT_W   = $clog2(MAX_WPB + 1);
    localparam logic [7:0] PAD_BYTE = SHA3_PAD ? 8'h06 : 8'h01;

    typedef enum logic [1:0] {FILL, FULL, LAST, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1151:0]    buf_q, buf_d;
    logic [IN_W-1:0]  last_word;
    int               rate_bits;
    int               word_pos;
    int               end_pos;

    always_comb begin
        case (mode_q)
            2'd0:    rate_bits = 1152;
            2'd1:    rate_bits = 1088;
            2'd2:    rate_bits = 832;
            default: rate_bits = 576;
        endcase
        word_pos = 1151 - int'(cnt_q) * IN_W;
        end_pos  = 1151 - rate_bits + 8;
    end

    // Final word: keep the valid MSB-side bytes, drop the pad byte in right after them.
    always_comb begin
        last_word = '0;
        for (int j = 0; j < BPW; j++) begin
            if (j < int'(bus.byte_num)) begin
                last_word[IN_W-1-8*j -: 8] = bus.in[IN_W-1-8*j -: 8];
            end else if (j == int'(bus.byte_num)) begin
                last_word[IN_W-1-8*j -: 8] = PAD_BYTE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        mode_d  = reset ? bus.mode : mode_q;
        case (state_q)
            FILL: begin
                if (bus.in_ready) begin
                    if (bus.is_last) begin
                        // Words after this one are already zero since the buffer is cleared per block.
                        buf_d[word_pos -: IN_W] = last_word;
                        buf_d[end_pos -: 8]     = buf_d[end_pos -: 8] | 8'h80;
                        state_d                 = LAST;
                    end else begin
                        buf_d[word_pos -: IN_W] = bus.in;
                        cnt_d                   = cnt_q + 1'b1;
                        if (int'(cnt_q) + 1 == rate_bits / IN_W) begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (bus.f_ack) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            LAST: begin
                if (bus.f_ack) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        mode_q <= mode_d;
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.out         = buf_q;
    assign bus.out_ready   = (state_q == FULL) || (state_q == LAST);
    assign bus.out_last    = (state_q == LAST);
    assign bus.buffer_full = (state_q != FILL);
endmodule

// File: tb/tb_keccak_padder_multi.sv
// Bench for keccak_padder_multi: four instances (32/64-bit x Keccak/SHA-3 pad) checked
// against a byte-level pad10*1 reference model.
module tb_keccak_padder_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Group 0 drives the 32-bit pair, group 1 the 64-bit pair; pair members differ only in pad byte.
    logic        reset_v    [2];
    logic [1:0]  mode_v     [2];
    logic [63:0] in_v       [2];
    logic        in_ready_v [2];
    logic        is_last_v  [2];
    logic [2:0]  byte_num_v [2];
    logic        f_ack_v    [2];

    logic [1151:0] out_o       [4];
    logic          out_ready_o [4];
    logic          out_last_o  [4];
    logic          full_o      [4];

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0]    msg_q [$];
    logic [1151:0] cap_blk [4];

    keccak_padder_multi_if #(.IN_W(32)) if32a ();
    keccak_padder_multi_if #(.IN_W(32)) if32b ();
    keccak_padder_multi_if #(.IN_W(64)) if64a ();
    keccak_padder_multi_if #(.IN_W(64)) if64b ();

    keccak_padder_multi #(.IN_W(32), .SHA3_PAD(1'b0)) dut32a (.clk(clk), .reset(reset_v[0]), .bus(if32a));
    keccak_padder_multi #(.IN_W(32), .SHA3_PAD(1'b1)) dut32b (.clk(clk), .reset(reset_v[0]), .bus(if32b));
    keccak_padder_multi #(.IN_W(64), .SHA3_PAD(1'b0)) dut64a (.clk(clk), .reset(reset_v[1]), .bus(if64a));
    keccak_padder_multi #(.IN_W(64), .SHA3_PAD(1'b1)) dut64b (.clk(clk), .reset(reset_v[1]), .bus(if64b));

    assign if32a.mode = mode_v[0];          assign if32b.mode = mode_v[0];
    assign if32a.in = in_v[0][31:0];        assign if32b.in = in_v[0][31:0];
    assign if32a.in_ready = in_ready_v[0];  assign if32b.in_ready = in_ready_v[0];
    assign if32a.is_last = is_last_v[0];    assign if32b.is_last = is_last_v[0];
    assign if32a.byte_num = byte_num_v[0][1:0]; assign if32b.byte_num = byte_num_v[0][1:0];
    assign if32a.f_ack = f_ack_v[0];        assign if32b.f_ack = f_ack_v[0];
    assign if64a.mode = mode_v[1];          assign if64b.mode = mode_v[1];
    assign if64a.in = in_v[1];              assign if64b.in = in_v[1];
    assign if64a.in_ready = in_ready_v[1];  assign if64b.in_ready = in_ready_v[1];
    assign if64a.is_last = is_last_v[1];    assign if64b.is_last = is_last_v[1];
    assign if64a.byte_num = byte_num_v[1];  assign if64b.byte_num = byte_num_v[1];
    assign if64a.f_ack = f_ack_v[1];        assign if64b.f_ack = f_ack_v[1];

    assign out_o[0] = if32a.out; assign out_o[1] = if32b.out;
    assign out_o[2] = if64a.out; assign out_o[3] = if64b.out;
    assign out_ready_o[0] = if32a.out_ready; assign out_ready_o[1] = if32b.out_ready;
    assign out_ready_o[2] = if64a.out_ready; assign out_ready_o[3] = if64b.out_ready;
    assign out_last_o[0] = if32a.out_last; assign out_last_o[1] = if32b.out_last;
    assign out_last_o[2] = if64a.out_last; assign out_last_o[3] = if64b.out_last;
    assign full_o[0] = if32a.buffer_full; assign full_o[1] = if32b.buffer_full;
    assign full_o[2] = if64a.buffer_full; assign full_o[3] = if64b.buffer_full;

    function automatic int rate_bytes(input logic [1:0] m);
        case (m)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    // Reference: message ++ pad ++ zeros, 0x80 ORed into the last rate byte of the last block.
    function automatic logic [1151:0] model_block(input int rb, input logic [7:0] pad, input int bi);
        logic [1151:0] blk;
        logic [7:0]    b;
        int            gi;
        int            len;
        blk = '0;
        len = msg_q.size();
        for (int k = 0; k < rb; k++) begin
            gi = bi * rb + k;
            b  = 8'h00;
            if (gi < len) b = msg_q[gi];
            else if (gi == len) b = pad;
            if (k == rb - 1 && bi == len / rb) b = b | 8'h80;
            blk[1151-8*k -: 8] = b;
        end
        return blk;
    endfunction

    function automatic int first_diff(input logic [1151:0] a, input logic [1151:0] b);
        for (int k = 0; k < 144; k++) begin
            if (a[1151-8*k -: 8] !== b[1151-8*k -: 8]) return k;
        end
        return 0;
    endfunction

    function automatic logic [63:0] make_word(input int bpw, input int wi);
        logic [63:0] w;
        int          idx;
        w = '0;
        for (int j = 0; j < bpw; j++) begin
            idx = wi * bpw + j;
            w[(bpw-1-j)*8 +: 8] = (idx < msg_q.size()) ? msg_q[idx] : 8'($urandom);
        end
        return w;
    endfunction

    task automatic do_reset(input int g, input logic [1:0] m);
        reset_v[g]    = 1'b1;
        mode_v[g]     = m;
        in_ready_v[g] = 1'b0;
        f_ack_v[g]    = 1'b0;
        is_last_v[g]  = 1'b0;
        @(negedge clk);
        reset_v[g] = 1'b0;
        mode_v[g]  = 2'($urandom);
    endtask

    // Streams msg_q through group g with random gaps and stalls, checking every cycle.
    task automatic run_message(input int g, input logic [1:0] m, input bit with_reset);
        int bpw, rb, wpb, nw, nb, wi, bi, cnt, cycles, holds, k, d;
        bit pending, finished, was_last, is_final;
        logic [1151:0] exp_b;
        bpw = g ? 8 : 4;
        rb  = rate_bytes(m);
        wpb = rb / bpw;
        nw  = msg_q.size() / bpw + 1;
        nb  = msg_q.size() / rb + 1;
        if (with_reset) do_reset(g, m);
        wi = 0; bi = 0; cnt = 0; cycles = 0; pending = 0; finished = 0;
        while (!finished && cycles < 4000) begin
            cycles++;
            if (pending) begin
                is_final = (bi == nb - 1);
                for (int p = 0; p < 2; p++) begin
                    k = 2 * g + p;
                    exp_b = model_block(rb, p ? 8'h06 : 8'h01, bi);
                    vectors++;
                    if (out_ready_o[k] !== 1'b1 || out_last_o[k] !== is_final || full_o[k] !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL block_flags inst%0d blk%0d: rdy/last/full got %b%b%b want 1%b1",
                                 k, bi, out_ready_o[k], out_last_o[k], full_o[k], is_final);
                    end
                    vectors++;
                    if (out_o[k] !== exp_b) begin
                        miscompares++;
                        d = first_diff(out_o[k], exp_b);
                        $display("[TB] FAIL block_data inst%0d blk%0d: byte %0d got %h want %h",
                                 k, bi, d, out_o[k][1151-8*d -: 8], exp_b[1151-8*d -: 8]);
                    end
                    cap_blk[k] = out_o[k];
                end
                // Keep offering the next word while the block waits for its ack.
                in_ready_v[g] = (wi < nw);
                in_v[g]       = make_word(bpw, wi);
                is_last_v[g]  = (wi == nw - 1);
                byte_num_v[g] = 3'(msg_q.size() % bpw);
                holds = 1 + $urandom_range(2);
                repeat (holds) begin
                    @(negedge clk);
                    for (int p = 0; p < 2; p++) begin
                        k = 2 * g + p;
                        vectors++;
                        if (out_o[k] !== model_block(rb, p ? 8'h06 : 8'h01, bi) || out_ready_o[k] !== 1'b1 || full_o[k] !== 1'b1) begin
                            miscompares++;
                            $display("[TB] FAIL stall_hold inst%0d blk%0d: rdy/full got %b%b want 11 (or block changed)",
                                     k, bi, out_ready_o[k], full_o[k]);
                        end
                    end
                end
                f_ack_v[g] = 1'b1;
                @(negedge clk);
                f_ack_v[g] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    k = 2 * g + p;
                    vectors++;
                    if (out_ready_o[k] !== 1'b0 || full_o[k] !== is_final) begin
                        miscompares++;
                        $display("[TB] FAIL after_ack inst%0d blk%0d: rdy/full got %b%b want 0%b",
                                 k, bi, out_ready_o[k], full_o[k], is_final);
                    end
                end
                if (is_final) finished = 1;
                bi++; cnt = 0; pending = 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    k = 2 * g + p;
                    vectors++;
                    if (out_ready_o[k] !== 1'b0 || full_o[k] !== 1'b0) begin
                        miscompares++;
                        $display("[TB] FAIL fill_flags inst%0d word%0d: rdy/full got %b%b want 00",
                                 k, wi, out_ready_o[k], full_o[k]);
                    end
                end
                if (wi < nw && $urandom_range(3) != 0) begin
                    was_last      = (wi == nw - 1);
                    in_v[g]       = make_word(bpw, wi);
                    in_ready_v[g] = 1'b1;
                    is_last_v[g]  = was_last;
                    byte_num_v[g] = was_last ? 3'(msg_q.size() % bpw) : 3'($urandom_range(bpw - 1));
                    @(negedge clk);
                    in_ready_v[g] = 1'b0;
                    wi++; cnt++;
                    if (cnt == wpb || was_last) pending = 1;
                end else begin
                    in_ready_v[g] = 1'b0;
                    in_v[g]       = {$urandom, $urandom};
                    is_last_v[g]  = 1'($urandom);
                    @(negedge clk);
                end
            end
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("[TB] FAIL timeout grp%0d: blocks got %0d want %0d", g, bi, nb);
        end
        // Once finished, nothing but reset may wake the padder.
        repeat (4) begin
            in_ready_v[g] = 1'($urandom);
            f_ack_v[g]    = 1'($urandom);
            is_last_v[g]  = 1'($urandom);
            in_v[g]       = {$urandom, $urandom};
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                k = 2 * g + p;
                vectors++;
                if (out_ready_o[k] !== 1'b0 || full_o[k] !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL done_idle inst%0d: rdy/full got %b%b want 01", k, out_ready_o[k], full_o[k]);
                end
            end
        end
        in_ready_v[g] = 1'b0;
        f_ack_v[g]    = 1'b0;
    endtask

    task automatic load_string(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic test_reset();
        do_reset(0, 2'd0);
        do_reset(1, 2'd0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_o[k] !== '0 || out_ready_o[k] !== 1'b0 || out_last_o[k] !== 1'b0 || full_o[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_state inst%0d: rdy/last/full got %b%b%b want 000, out zero %b",
                         k, out_ready_o[k], out_last_o[k], full_o[k], out_o[k] == '0);
            end
        end
    endtask

    task automatic test_hello_world(input bit with_reset);
        logic [1151:0] e;
        load_string("Hello, world!");
        run_message(0, 2'd1, with_reset);
        for (int p = 0; p < 2; p++) begin
            e = '0;
            e[1151:1048] = "Hello, world!";
            e[1047:1040] = p ? 8'h06 : 8'h01;
            e[71:64]     = 8'h80;
            vectors++;
            if (cap_blk[p] !== e) begin
                miscompares++;
                $display("[TB] FAIL hello_world inst%0d: byte %0d got %h want %h", p,
                         first_diff(cap_blk[p], e), cap_blk[p][1151-8*first_diff(cap_blk[p], e) -: 8],
                         e[1151-8*first_diff(cap_blk[p], e) -: 8]);
            end
        end
    endtask

    task automatic test_empty();
        logic [1151:0] e;
        msg_q.delete();
        run_message(0, 2'd3, 1'b1);
        for (int p = 0; p < 2; p++) begin
            e = '0;
            e[1151:1144] = p ? 8'h06 : 8'h01;
            e[583:576]   = 8'h80;
            vectors++;
            if (cap_blk[p] !== e) begin
                miscompares++;
                $display("[TB] FAIL empty_msg inst%0d: top byte got %h want %h, rate end got %h want 80",
                         p, cap_blk[p][1151:1144], e[1151:1144], cap_blk[p][583:576]);
            end
        end
    endtask

    task automatic test_multi_block();
        msg_q.delete();
        for (int i = 0; i < 136; i++) msg_q.push_back(8'($urandom));
        msg_q.push_back("a"); msg_q.push_back("b"); msg_q.push_back("c");
        run_message(0, 2'd1, 1'b1);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (cap_blk[p][1151:1128] !== 24'h616263 || cap_blk[p][1127:1120] !== (p ? 8'h06 : 8'h01)) begin
                miscompares++;
                $display("[TB] FAIL multi_block inst%0d: head got %h pad got %h want 616263 pad %h",
                         p, cap_blk[p][1151:1128], cap_blk[p][1127:1120], p ? 8'h06 : 8'h01);
            end
        end
    endtask

    task automatic test_shared_pad();
        msg_q.delete();
        for (int i = 0; i < 71; i++) msg_q.push_back(8'($urandom));
        run_message(1, 2'd3, 1'b1);
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (cap_blk[2+p][583:576] !== (p ? 8'h86 : 8'h81) || cap_blk[2+p][575:0] !== '0) begin
                miscompares++;
                $display("[TB] FAIL shared_pad inst%0d: got %h want %h", 2 + p,
                         cap_blk[2+p][583:576], p ? 8'h86 : 8'h81);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0, 2'd1);
        for (int i = 0; i < 5; i++) begin
            in_v[0]       = {$urandom, $urandom};
            in_ready_v[0] = 1'b1;
            is_last_v[0]  = 1'b0;
            @(negedge clk);
        end
        in_ready_v[0] = 1'b0;
        reset_v[0]    = 1'b1;
        mode_v[0]     = 2'd1;
        @(negedge clk);
        reset_v[0] = 1'b0;
        mode_v[0]  = 2'd3;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_o[k] !== '0 || full_o[k] !== 1'b0 || out_ready_o[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_mid inst%0d: rdy/full got %b%b want 00, out zero %b",
                         k, out_ready_o[k], full_o[k], out_o[k] == '0);
            end
        end
        test_hello_world(1'b0);
    endtask

    task automatic test_random();
        int g;
        int len;
        logic [1:0] m;
        for (int n = 0; n < 12; n++) begin
            g   = $urandom_range(1);
            m   = 2'($urandom);
            len = $urandom_range(2 * rate_bytes(m) + 10);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            run_message(g, m, 1'b1);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            reset_v[g] = 1'b1; mode_v[g] = 2'd0; in_v[g] = '0; in_ready_v[g] = 1'b0;
            is_last_v[g] = 1'b0; byte_num_v[g] = '0; f_ack_v[g] = 1'b0;
        end
        @(negedge clk);
        $display("[TB] start");
        test_reset();
        test_hello_world(1'b1);
        test_empty();
        test_multi_block();
        test_shared_pad();
        test_reset_mid();
        test_random();
        test_hello_world(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
